// File: rtl/s32x_fb_arbiter_if.sv
// s32x_fb_arbiter_if: groups the display, refresh, fill, CPU and framebuffer
// signals of the S32X framebuffer arbiter. The arbiter uses the slave modport;
// the requester/memory side uses the master modport.
interface s32x_fb_arbiter_if;
  // display fetch port
  logic        DISP_REQ;
  logic [15:0] DISP_A;
  logic [15:0] DISP_Q;
  logic        DISP_ACK;
  // line-end refresh
  logic        RFRH_START;
  logic        FEN;
  // fill engine setup and status
  logic        FILL_START;
  logic [7:0]  FILL_LEN;
  logic [15:0] FILL_ADDR;
  logic [15:0] FILL_DATA;
  logic        FILL_BUSY;
  logic [15:0] FILL_ADDR_Q;
  // CPU write port
  logic        WR_REQ;
  logic [15:0] WR_A;
  logic [15:0] WR_D;
  logic [1:0]  WR_BE;
  logic        OVWR;
  logic        WR_ACK;
  // CPU read port
  logic        RD_REQ;
  logic [15:0] RD_A;
  logic [15:0] RD_Q;
  logic        RD_ACK;
  // framebuffer memory
  logic [15:0] FB_A;
  logic [15:0] FB_DO;
  logic [1:0]  FB_WE;
  logic        FB_RD;
  logic [15:0] FB_DI;

  modport master (
    output DISP_REQ, DISP_A, RFRH_START,
    output FILL_START, FILL_LEN, FILL_ADDR, FILL_DATA,
    output WR_REQ, WR_A, WR_D, WR_BE, OVWR,
    output RD_REQ, RD_A, FB_DI,
    input  DISP_Q, DISP_ACK, FEN, FILL_BUSY, FILL_ADDR_Q,
    input  WR_ACK, RD_Q, RD_ACK, FB_A, FB_DO, FB_WE, FB_RD
  );

  modport slave (
    input  DISP_REQ, DISP_A, RFRH_START,
    input  FILL_START, FILL_LEN, FILL_ADDR, FILL_DATA,
    input  WR_REQ, WR_A, WR_D, WR_BE, OVWR,
    input  RD_REQ, RD_A, FB_DI,
    output DISP_Q, DISP_ACK, FEN, FILL_BUSY, FILL_ADDR_Q,
    output WR_ACK, RD_Q, RD_ACK, FB_A, FB_DO, FB_WE, FB_RD
  );
endinterface

// File: rtl/s32x_fb_arbiter.sv
// s32x_fb_arbiter: single-owner framebuffer arbiter for display fetch, fill
// engine, CPU write and CPU read. Fixed priority DISP > FILL > WRITE > READ,
// every access lasts ACC_CYC cycles, and a refresh window blocks everything
// except display fetches.
// Optional feature: define S32X_FB_OVERWRITE_EN to enable overwrite-image
// writes (OVWR=1 suppresses byte lanes whose data byte is zero).
module s32x_fb_arbiter #(
  parameter int ACC_CYC  = 3,
  parameter int RFRH_CYC = 40
) (
  input logic              CLK,
  input logic              RST,
  s32x_fb_arbiter_if.slave bus
);

  localparam int                RCNT_W    = (RFRH_CYC > 1) ? $clog2(RFRH_CYC) : 1;
  localparam logic [RCNT_W-1:0] RFRH_LOAD = RCNT_W'(RFRH_CYC - 1);
  localparam logic [2:0]        ACC_LOAD  = 3'(ACC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISP  = 3'd1,
    FILL  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  // Fill walks only the low address byte; the page byte never changes.
  function automatic logic [15:0] fill_next(input logic [15:0] a);
    return {a[15:8], a[7:0] + 8'd1};
  endfunction

  state_t              state_q, state_d;
  logic                disp_pend_q, disp_pend_d;
  logic [15:0]         disp_a_q, disp_a_d;
  logic                wr_req_q, wr_req_d;
  logic                rd_req_q, rd_req_d;
  logic                rfrh_act_q, rfrh_act_d;
  logic [RCNT_W-1:0]   rfrh_cnt_q, rfrh_cnt_d;
  logic                fill_busy_q, fill_busy_d;
  logic [7:0]          fill_cnt_q, fill_cnt_d;
  logic [15:0]         fill_addr_q, fill_addr_d;
  logic [15:0]         fill_data_q, fill_data_d;
  logic [2:0]          acc_cnt_q, acc_cnt_d;
  logic [15:0]         fb_a_q, fb_a_d;
  logic [15:0]         fb_do_q, fb_do_d;
  logic [1:0]          fb_we_q, fb_we_d;
  logic                fb_rd_q, fb_rd_d;
  logic [15:0]         disp_word_q, disp_word_d;
  logic [15:0]         rd_word_q, rd_word_d;
  logic                disp_ack_q, disp_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;

  logic [1:0]          wr_we;
  logic                wr_req_v;
  logic                rd_req_v;

`ifdef S32X_FB_OVERWRITE_EN
  // Overwrite image: a lane is written only when enabled and its byte is nonzero.
  function automatic logic [1:0] ovwr_lanes(input logic [1:0]  be,
                                            input logic [15:0] d,
                                            input logic        ovwr);
    logic [1:0] nz;
    nz = {|d[15:8], |d[7:0]};
    return ovwr ? (be & nz) : be;
  endfunction

  assign wr_we = ovwr_lanes(bus.WR_BE, bus.WR_D, bus.OVWR);
`else
  logic ovwr_unused;
  assign wr_we       = bus.WR_BE;
  assign ovwr_unused = bus.OVWR;
`endif

  // A level request is not re-granted in the cycle its ACK is showing;
  // still high one cycle later, it counts as a fresh request.
  assign wr_req_v = wr_req_q & ~wr_ack_q;
  assign rd_req_v = rd_req_q & ~rd_ack_q;

  // Next-state and datapath: refresh timer, fill setup, grant and access sequencing.
  always_comb begin
    state_d     = state_q;
    disp_pend_d = disp_pend_q;
    disp_a_d    = disp_a_q;
    wr_req_d    = bus.WR_REQ;
    rd_req_d    = bus.RD_REQ;
    rfrh_act_d  = rfrh_act_q;
    rfrh_cnt_d  = rfrh_cnt_q;
    fill_busy_d = fill_busy_q;
    fill_cnt_d  = fill_cnt_q;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    acc_cnt_d   = acc_cnt_q;
    fb_a_d      = fb_a_q;
    fb_do_d     = fb_do_q;
    fb_we_d     = 2'b00;
    fb_rd_d     = fb_rd_q;
    disp_word_d = disp_word_q;
    rd_word_d   = rd_word_q;
    disp_ack_d  = 1'b0;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;

    // Refresh window: a start (re)loads the counter, window ends after 0.
    if (bus.RFRH_START) begin
      rfrh_act_d = 1'b1;
      rfrh_cnt_d = RFRH_LOAD;
    end else if (rfrh_act_q) begin
      if (rfrh_cnt_q == '0) begin
        rfrh_act_d = 1'b0;
      end else begin
        rfrh_cnt_d = rfrh_cnt_q - RCNT_W'(1);
      end
    end

    // A new fill is accepted only when no fill is running.
    if (bus.FILL_START && !fill_busy_q) begin
      fill_busy_d = 1'b1;
      fill_cnt_d  = bus.FILL_LEN;
      fill_addr_d = bus.FILL_ADDR;
      fill_data_d = bus.FILL_DATA;
    end

    case (state_q)
      IDLE: begin
        if (disp_pend_q) begin
          state_d     = DISP;
          disp_pend_d = 1'b0;
          acc_cnt_d   = ACC_LOAD;
          fb_a_d      = disp_a_q;
          fb_rd_d     = 1'b1;
        end else if (!rfrh_act_q && fill_busy_q) begin
          state_d   = FILL;
          acc_cnt_d = ACC_LOAD;
          fb_a_d    = fill_addr_q;
          fb_do_d   = fill_data_q;
          fb_we_d   = 2'b11;
        end else if (!rfrh_act_q && wr_req_v) begin
          state_d   = WRITE;
          acc_cnt_d = ACC_LOAD;
          fb_a_d    = bus.WR_A;
          fb_do_d   = bus.WR_D;
          fb_we_d   = wr_we;
        end else if (!rfrh_act_q && rd_req_v) begin
          state_d   = READ;
          acc_cnt_d = ACC_LOAD;
          fb_a_d    = bus.RD_A;
          fb_rd_d   = 1'b1;
        end
      end
      DISP, FILL, WRITE, READ: begin
        if (acc_cnt_q == 3'd0) begin
          state_d = IDLE;
          fb_rd_d = 1'b0;
          case (state_q)
            DISP: begin
              disp_word_d = bus.FB_DI;
              disp_ack_d  = 1'b1;
            end
            READ: begin
              rd_word_d = bus.FB_DI;
              rd_ack_d  = 1'b1;
            end
            WRITE: begin
              wr_ack_d = 1'b1;
            end
            FILL: begin
              fill_addr_d = fill_next(fill_addr_q);
              if (fill_cnt_q == 8'd0) begin
                fill_busy_d = 1'b0;
              end else begin
                fill_cnt_d = fill_cnt_q - 8'd1;
              end
            end
            default: ;
          endcase
        end else begin
          acc_cnt_d = acc_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A display request always lands in the pending slot; a newer one
    // replaces an older pending address.
    if (bus.DISP_REQ) begin
      disp_pend_d = 1'b1;
      disp_a_d    = bus.DISP_A;
    end
  end

  // State and datapath registers; reset aborts any access or fill at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      disp_pend_q <= 1'b0;
      disp_a_q    <= 16'h0000;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      rfrh_act_q  <= 1'b0;
      rfrh_cnt_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_cnt_q  <= 8'd0;
      fill_addr_q <= 16'h0000;
      fill_data_q <= 16'h0000;
      acc_cnt_q   <= 3'd0;
      fb_a_q      <= 16'h0000;
      fb_do_q     <= 16'h0000;
      fb_we_q     <= 2'b00;
      fb_rd_q     <= 1'b0;
      disp_word_q <= 16'h0000;
      rd_word_q   <= 16'h0000;
      disp_ack_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_pend_q <= disp_pend_d;
      disp_a_q    <= disp_a_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      rfrh_act_q  <= rfrh_act_d;
      rfrh_cnt_q  <= rfrh_cnt_d;
      fill_busy_q <= fill_busy_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      acc_cnt_q   <= acc_cnt_d;
      fb_a_q      <= fb_a_d;
      fb_do_q     <= fb_do_d;
      fb_we_q     <= fb_we_d;
      fb_rd_q     <= fb_rd_d;
      disp_word_q <= disp_word_d;
      rd_word_q   <= rd_word_d;
      disp_ack_q  <= disp_ack_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

  assign bus.DISP_Q      = disp_word_q;
  assign bus.DISP_ACK    = disp_ack_q;
  assign bus.FEN         = fill_busy_q | rfrh_act_q;
  assign bus.FILL_BUSY   = fill_busy_q;
  assign bus.FILL_ADDR_Q = fill_addr_q;
  assign bus.WR_ACK      = wr_ack_q;
  assign bus.RD_Q        = rd_word_q;
  assign bus.RD_ACK      = rd_ack_q;
  assign bus.FB_A        = fb_a_q;
  assign bus.FB_DO       = fb_do_q;
  assign bus.FB_WE       = fb_we_q;
  assign bus.FB_RD       = fb_rd_q;

endmodule

// File: tb/tb_s32x_fb_arbiter.sv
// tb_s32x_fb_arbiter: scoreboard bench for s32x_fb_arbiter (ACC_CYC=3,
// RFRH_CYC=40). Framebuffer read data is modelled as FB_A ^ 16'h5A5A.
module tb_s32x_fb_arbiter;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  we;
  } wr_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   wr_ack_cnt;
  wr_t  wq[$];
  logic [15:0] dq[$];
  logic [15:0] rq[$];

  s32x_fb_arbiter_if bus();

  s32x_fb_arbiter #(.ACC_CYC(3), .RFRH_CYC(40)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  assign bus.FB_DI = bus.FB_A ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0=DISP_ACK 1=WR_ACK 2=RD_ACK 3=FILL_BUSY low; lat=-1 when budget expires
  task automatic wait_flag(input int sel, input int budget, output int lat);
    logic hit;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      case (sel)
        0:       hit = bus.DISP_ACK;
        1:       hit = bus.WR_ACK;
        2:       hit = bus.RD_ACK;
        default: hit = ~bus.FILL_BUSY;
      endcase
      if (hit) begin
        lat = i;
        break;
      end
    end
  endtask

  // scoreboard: pop expected writes/fetches as the DUT produces them
  always @(negedge clk) begin
    if (bus.FB_WE != 2'b00) begin
      if (wq.size() == 0) begin
        check_eq("wr_unexp", {14'd0, bus.FB_WE}, 32'd0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check_eq("fb_a", {16'd0, bus.FB_A}, {16'd0, e.a});
        check_eq("fb_do", {16'd0, bus.FB_DO}, {16'd0, e.d});
        check_eq("fb_we", {30'd0, bus.FB_WE}, {30'd0, e.we});
      end
    end
    if (bus.DISP_ACK) begin
      if (dq.size() == 0) check_eq("disp_unexp", {31'd0, bus.DISP_ACK}, 32'd0);
      else check_eq("disp_q", {16'd0, bus.DISP_Q}, {16'd0, dq.pop_front()});
    end
    if (bus.RD_ACK) begin
      if (rq.size() == 0) check_eq("rd_unexp", {31'd0, bus.RD_ACK}, 32'd0);
      else check_eq("rd_q", {16'd0, bus.RD_Q}, {16'd0, rq.pop_front()});
    end
    if (bus.WR_ACK) wr_ack_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n_d, n_w, n_r, fen_bad, acks0, nwe;
    logic [1:0] ov_we;
    total = 0; bad = 0; wr_ack_cnt = 0;
    rst = 1'b1;
    bus.DISP_REQ = 0; bus.DISP_A = 0; bus.RFRH_START = 0;
    bus.FILL_START = 0; bus.FILL_LEN = 0; bus.FILL_ADDR = 0; bus.FILL_DATA = 0;
    bus.WR_REQ = 0; bus.WR_A = 0; bus.WR_D = 0; bus.WR_BE = 0; bus.OVWR = 0;
    bus.RD_REQ = 0; bus.RD_A = 0;
    repeat (3) tick();

    // reset state
    check_eq("rst_ctl", {26'd0, bus.FEN, bus.FILL_BUSY, bus.DISP_ACK, bus.WR_ACK, bus.RD_ACK, bus.FB_RD}, 32'd0);
    check_eq("rst_we", {30'd0, bus.FB_WE}, 32'd0);
    check_eq("rst_fb", {bus.FB_A, bus.FB_DO}, 32'd0);
    check_eq("rst_q", {bus.DISP_Q, bus.RD_Q}, 32'd0);
    check_eq("rst_fa", {16'd0, bus.FILL_ADDR_Q}, 32'd0);
    rst = 1'b0;
    tick();

    // simultaneous DISP, WRITE, READ
    bus.DISP_REQ = 1; bus.DISP_A = 16'h0100;
    bus.WR_REQ = 1; bus.WR_A = 16'h0200; bus.WR_D = 16'h1234; bus.WR_BE = 2'b11;
    bus.RD_REQ = 1; bus.RD_A = 16'h0300;
    dq.push_back(16'h0100 ^ 16'h5A5A);
    wq.push_back('{a: 16'h0200, d: 16'h1234, we: 2'b11});
    rq.push_back(16'h0300 ^ 16'h5A5A);
    n_d = 0; n_w = 0; n_r = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) bus.DISP_REQ = 0;
      if (bus.DISP_ACK && n_d == 0) n_d = i;
      if (bus.WR_ACK && n_w == 0) begin n_w = i; bus.WR_REQ = 0; end
      if (bus.RD_ACK && n_r == 0) begin n_r = i; bus.RD_REQ = 0; end
    end
    check_eq("pri_disp", n_d, 5);
    check_eq("pri_wr", n_w, 9);
    check_eq("pri_rd", n_r, 13);
    check_eq("disp_hold", {16'd0, bus.DISP_Q}, {16'd0, 16'h0100 ^ 16'h5A5A});

    // pending display address overwritten while a write runs
    bus.WR_REQ = 1; bus.WR_A = 16'h0210; bus.WR_D = 16'h00FF; bus.WR_BE = 2'b01;
    wq.push_back('{a: 16'h0210, d: 16'h00FF, we: 2'b01});
    dq.push_back(16'h0800 ^ 16'h5A5A);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 2) begin bus.DISP_REQ = 1; bus.DISP_A = 16'h0700; end
      if (i == 3) bus.DISP_A = 16'h0800;
      if (i == 4) bus.DISP_REQ = 0;
      if (bus.WR_ACK) bus.WR_REQ = 0;
    end
    check_eq("ovr_dq_empty", dq.size(), 0);

    // fill with low-byte wrap
    bus.FILL_START = 1; bus.FILL_ADDR = 16'h12FE; bus.FILL_LEN = 8'd3; bus.FILL_DATA = 16'hA5A5;
    wq.push_back('{a: 16'h12FE, d: 16'hA5A5, we: 2'b11});
    wq.push_back('{a: 16'h12FF, d: 16'hA5A5, we: 2'b11});
    wq.push_back('{a: 16'h1200, d: 16'hA5A5, we: 2'b11});
    wq.push_back('{a: 16'h1201, d: 16'hA5A5, we: 2'b11});
    tick();
    bus.FILL_START = 0;
    check_eq("fill_busy", {30'd0, bus.FILL_BUSY, bus.FEN}, 32'd3);
    wait_flag(3, 40, lat);
    check_eq("fill_done", (lat > 0), 1);
    check_eq("fill_addr_q", {16'd0, bus.FILL_ADDR_Q}, 32'h1202);
    check_eq("fill_wq", wq.size(), 0);
    tick();

    // FILL_START while busy is ignored
    bus.FILL_START = 1; bus.FILL_ADDR = 16'h3400; bus.FILL_LEN = 8'd2; bus.FILL_DATA = 16'h1111;
    for (int i = 0; i < 3; i++) wq.push_back('{a: 16'h3400 + 16'(i), d: 16'h1111, we: 2'b11});
    tick();
    bus.FILL_START = 0;
    tick();
    bus.FILL_START = 1; bus.FILL_ADDR = 16'h5600; bus.FILL_LEN = 8'd5; bus.FILL_DATA = 16'h2222;
    tick();
    bus.FILL_START = 0;
    wait_flag(3, 40, lat);
    check_eq("busy_start_done", (lat > 0), 1);
    check_eq("busy_start_addr", {16'd0, bus.FILL_ADDR_Q}, 32'h3403);
    check_eq("busy_start_wq", wq.size(), 0);
    tick();

    // refresh window blocks the write, display still served
    bus.RFRH_START = 1;
    bus.WR_REQ = 1; bus.WR_A = 16'h0400; bus.WR_D = 16'hBEEF; bus.WR_BE = 2'b10;
    wq.push_back('{a: 16'h0400, d: 16'hBEEF, we: 2'b10});
    dq.push_back(16'h0500 ^ 16'h5A5A);
    acks0 = wr_ack_cnt; fen_bad = 0; n_d = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) bus.RFRH_START = 0;
      if (i == 10) begin bus.DISP_REQ = 1; bus.DISP_A = 16'h0500; end
      if (i == 11) bus.DISP_REQ = 0;
      if (bus.FEN !== 1'b1) fen_bad++;
      if (bus.DISP_ACK && n_d == 0) n_d = i - 10;
    end
    check_eq("rf_fen", fen_bad, 0);
    check_eq("rf_no_wr", wr_ack_cnt - acks0, 0);
    check_eq("rf_disp_seen", (n_d > 0), 1);
    check_eq("rf_disp_lat", (n_d <= 8), 1);
    tick();
    check_eq("rf_fen_end", {31'd0, bus.FEN}, 32'd0);
    wait_flag(1, 20, lat);
    bus.WR_REQ = 0;
    check_eq("rf_wr_after", lat, 4);
    tick();

    // overwrite-image write
`ifdef S32X_FB_OVERWRITE_EN
    ov_we = 2'b01;
`else
    ov_we = 2'b11;
`endif
    bus.WR_REQ = 1; bus.OVWR = 1; bus.WR_A = 16'h0600; bus.WR_D = 16'h007F; bus.WR_BE = 2'b11;
    wq.push_back('{a: 16'h0600, d: 16'h007F, we: ov_we});
    wait_flag(1, 20, lat);
    bus.WR_REQ = 0;
    check_eq("ovwr_lat", lat, 5);
    tick();
    // all lanes zero: still a full access with WR_ACK
    bus.WR_REQ = 1; bus.WR_A = 16'h0610; bus.WR_D = 16'h0000; bus.WR_BE = 2'b11;
`ifndef S32X_FB_OVERWRITE_EN
    wq.push_back('{a: 16'h0610, d: 16'h0000, we: 2'b11});
`endif
    wait_flag(1, 20, lat);
    bus.WR_REQ = 0; bus.OVWR = 0;
    check_eq("ovwr_zero_lat", lat, 5);
    tick();

    // single read
    bus.RD_REQ = 1; bus.RD_A = 16'hC0DE;
    rq.push_back(16'hC0DE ^ 16'h5A5A);
    wait_flag(2, 20, lat);
    bus.RD_REQ = 0;
    check_eq("rd_lat", lat, 5);
    tick();

    // reset during the second fill write
    bus.FILL_START = 1; bus.FILL_ADDR = 16'h7000; bus.FILL_LEN = 8'd5; bus.FILL_DATA = 16'h3333;
    wq.push_back('{a: 16'h7000, d: 16'h3333, we: 2'b11});
    wq.push_back('{a: 16'h7001, d: 16'h3333, we: 2'b11});
    tick();
    bus.FILL_START = 0;
    nwe = (bus.FB_WE != 2'b00) ? 1 : 0;
    for (int i = 0; i < 30 && nwe < 2; i++) begin
      tick();
      if (bus.FB_WE != 2'b00) nwe++;
    end
    check_eq("rstf_second", nwe, 2);
    rst = 1'b1;
    tick();
    check_eq("rstf_state", {29'd0, bus.FILL_BUSY, bus.FEN, |bus.FB_WE}, 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    check_eq("rstf_idle", {31'd0, bus.FILL_BUSY}, 32'd0);

    check_eq("end_wq", wq.size(), 0);
    check_eq("end_dq", dq.size(), 0);
    check_eq("end_rq", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
